mem_wb_skid_reg: RTL

- Parametrised successor to the MEM/WB pipeline stage register.
- Carries the write-back bundle (wb_en, mem_r_en, ALU result, memory data, destination register) from the MEM stage to the WB stage.
- Replaces the global freeze with a per-stage valid/ready handshake. A one-entry skid buffer means downstream back-pressure never drops or duplicates an instruction, and in_ready is fully registered.
- Adds synchronous flush (bubble insertion), an occupancy output, and the pre-muxed write-back value.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_entry_reg.sv | 63 ++++++
 rtl/mem_wb_skid_reg.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage registers:
// state encoding, default field widths and a small occupancy helper.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEST_W = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Number of valid entries in a main+skid pair (0, 1 or 2).
    function automatic logic [1:0] occ_count(input logic main_valid, input logic skid_valid);
        return {main_valid & skid_valid, main_valid ^ skid_valid};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot of a stage register: valid bit plus the write-back bundle.
// clear_ctrl drops only valid/control bits; rst zeroes every field.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEST_W = DEF_DEST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic              new_wb_en,
    input  logic              new_mem_r_en,
    input  logic [DATA_W-1:0] new_alu_res,
    input  logic [DATA_W-1:0] new_mem_data,
    input  logic [DEST_W-1:0] new_dest,
    output logic              valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] mem_data,
    output logic [DEST_W-1:0] dest
);

    logic              valid_reg;
    logic              wb_en_reg;
    logic              mem_r_en_reg;
    logic [DATA_W-1:0] alu_res_reg;
    logic [DATA_W-1:0] mem_data_reg;
    logic [DEST_W-1:0] dest_reg;

    // clear_ctrl outranks load so a flush always wins over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            wb_en_reg    <= 1'b0;
            mem_r_en_reg <= 1'b0;
            alu_res_reg  <= '0;
            mem_data_reg <= '0;
            dest_reg     <= '0;
        end else if (clear_ctrl) begin
            valid_reg    <= 1'b0;
            wb_en_reg    <= 1'b0;
            mem_r_en_reg <= 1'b0;
        end else if (load) begin
            valid_reg    <= 1'b1;
            wb_en_reg    <= new_wb_en;
            mem_r_en_reg <= new_mem_r_en;
            alu_res_reg  <= new_alu_res;
            mem_data_reg <= new_mem_data;
            dest_reg     <= new_dest;
        end
    end

    assign valid    = valid_reg;
    assign wb_en    = wb_en_reg;
    assign mem_r_en = mem_r_en_reg;
    assign alu_res  = alu_res_reg;
    assign mem_data = mem_data_reg;
    assign dest     = dest_reg;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush, occupancy count and the pre-muxed write-back value.
module mem_wb_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEST_W = DEF_DEST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_wb_value,
    output logic [1:0]        occupancy
);

    localparam int MAIN = 0;
    localparam int SKID = 1;

    pipe_state_e state_reg, state_next;

    logic [1:0]        ent_load;
    logic [1:0]        ent_clr;
    logic [1:0]        ent_new_wb_en;
    logic [1:0]        ent_new_mem_r_en;
    logic [DATA_W-1:0] ent_new_alu   [2];
    logic [DATA_W-1:0] ent_new_mem   [2];
    logic [DEST_W-1:0] ent_new_dest  [2];
    logic [1:0]        ent_valid;
    logic [1:0]        ent_wb_en;
    logic [1:0]        ent_mem_r_en;
    logic [DATA_W-1:0] ent_alu       [2];
    logic [DATA_W-1:0] ent_mem       [2];
    logic [DEST_W-1:0] ent_dest      [2];

    logic in_fire;
    logic out_fire;
    logic main_from_skid;

    assign in_ready  = (state_reg != ST_SKID);
    assign out_valid = ent_valid[MAIN];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ent_load       = 2'b00;
        ent_clr        = 2'b00;
        main_from_skid = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
            ent_clr    = 2'b11;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        ent_load[MAIN] = 1'b1;
                        state_next     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        ent_load[MAIN] = 1'b1;
                    end else if (in_fire) begin
                        ent_load[SKID] = 1'b1;
                        state_next     = ST_SKID;
                    end else if (out_fire) begin
                        ent_clr[MAIN]  = 1'b1;
                        state_next     = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // Upstream is stalled here, so only the skid can refill main.
                    if (out_fire) begin
                        ent_load[MAIN] = 1'b1;
                        ent_clr[SKID]  = 1'b1;
                        main_from_skid = 1'b1;
                        state_next     = ST_FULL;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    ent_clr    = 2'b11;
                end
            endcase
        end
    end

    assign ent_new_wb_en[MAIN]    = main_from_skid ? ent_wb_en[SKID]    : in_wb_en;
    assign ent_new_mem_r_en[MAIN] = main_from_skid ? ent_mem_r_en[SKID] : in_mem_r_en;
    assign ent_new_alu[MAIN]      = main_from_skid ? ent_alu[SKID]      : in_alu_res;
    assign ent_new_mem[MAIN]      = main_from_skid ? ent_mem[SKID]      : in_mem_data;
    assign ent_new_dest[MAIN]     = main_from_skid ? ent_dest[SKID]     : in_dest;

    assign ent_new_wb_en[SKID]    = in_wb_en;
    assign ent_new_mem_r_en[SKID] = in_mem_r_en;
    assign ent_new_alu[SKID]      = in_alu_res;
    assign ent_new_mem[SKID]      = in_mem_data;
    assign ent_new_dest[SKID]     = in_dest;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        pipe_entry_reg #(
            .DATA_W(DATA_W),
            .DEST_W(DEST_W)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .load        (ent_load[gi]),
            .clear_ctrl  (ent_clr[gi]),
            .new_wb_en   (ent_new_wb_en[gi]),
            .new_mem_r_en(ent_new_mem_r_en[gi]),
            .new_alu_res (ent_new_alu[gi]),
            .new_mem_data(ent_new_mem[gi]),
            .new_dest    (ent_new_dest[gi]),
            .valid       (ent_valid[gi]),
            .wb_en       (ent_wb_en[gi]),
            .mem_r_en    (ent_mem_r_en[gi]),
            .alu_res     (ent_alu[gi]),
            .mem_data    (ent_mem[gi]),
            .dest        (ent_dest[gi])
        );
    end

    assign out_wb_en    = ent_valid[MAIN] & ent_wb_en[MAIN];
    assign out_mem_r_en = ent_valid[MAIN] & ent_mem_r_en[MAIN];
    assign out_alu_res  = ent_alu[MAIN];
    assign out_mem_data = ent_mem[MAIN];
    assign out_dest     = ent_dest[MAIN];
    assign out_wb_value = out_mem_r_en ? ent_mem[MAIN] : ent_alu[MAIN];
    assign occupancy    = occ_count(ent_valid[MAIN], ent_valid[SKID]);

endmodule
